serial_sub4: RTL and testbench

- Bit-serial unsigned subtractor: computes Diff = A − B − Bin through one full-subtractor cell and a registered borrow, one bit per clock, LSB first.
- Companion to the team's combinational 4-bit ripple adder (FA4); the inverse arithmetic operation in sequential form.
- Sits beside FA4 in the arithmetic block set, trading latency for one-cell area.
- Start/done handshake toward a controller or testbench.

---
 rtl/serial_sub4.sv | 89 ++++++++
 tb/tb_serial_sub4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, one full-subtractor cell,
// LSB first, with a start/done handshake.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one operand bit per clock, WIDTH clocks
  // DONE  | single cycle, Diff/Bout freshly updated; start may chain
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_a, bit_b, d_bit, borrow_nxt, last_bit, accept;

  assign bit_a      = a_sr[0];
  assign bit_b      = b_sr[0];
  assign d_bit      = bit_a ^ bit_b ^ borrow;
  assign borrow_nxt = (~bit_a & bit_b) | (~bit_a & borrow) | (bit_b & borrow);
  assign res_nxt    = {d_bit, res_sr};
  assign last_bit   = (cnt == CW'(WIDTH - 1));
  assign accept     = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      borrow <= Bin;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= borrow_nxt;
      res_sr <= res_nxt[WIDTH-1:1];
      cnt    <= cnt + CW'(1);
      // Outputs only move on the completion edge so the old result stays visible
      if (last_bit) begin
        Diff <= res_nxt;
        Bout <= borrow_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Scoreboard bench for serial_sub4: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_serial_sub4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A, B;
  logic       Bin;
  logic       busy, done;
  logic [3:0] Diff;
  logic       Bout;

  int total = 0;
  int bad   = 0;
  int issued = 0;
  int dones  = 0;

  logic [4:0] exp_q[$];
  logic [3:0] prev_d;
  logic       prev_b;

  serial_sub4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("diff", int'(Diff), int'(e[3:0]));
        chk("bout", int'(Bout), int'(e[4]));
      end
    end
  end

  // Called just after a negedge. Returns just after the negedge where done is seen,
  // so a following call chains back-to-back through the DONE cycle.
  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                    input logic [3:0] ed, input logic eb, input bit glitch);
    int edges, busy_cycles;
    start = 1'b1; A = a; B = b; Bin = bin;
    exp_q.push_back({eb, ed});
    issued++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = a ^ b; Bin = ~bin;
    edges = 0; busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) begin
        busy_cycles++;
        chk("diff_hold", int'(Diff), int'(prev_d));
        chk("bout_hold", int'(Bout), int'(prev_b));
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (glitch && edges == 1) begin
        start = 1'b1; A = 4'b1111; B = 4'b0000; Bin = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_latency", edges, 4);
    chk("busy_cycles", busy_cycles, 4);
    chk("busy_in_done", int'(busy), 0);
    prev_d = ed; prev_b = eb;
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] r;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    prev_d = '0; prev_b = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(Diff), 0);
    chk("rst_bout", int'(Bout), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op(4'b0110, 4'b0100, 1'b0, 4'b0010, 1'b0, 0);
    idle_cycle();
    op(4'b1000, 4'b1001, 1'b1, 4'b1110, 1'b1, 0);
    op(4'b1110, 4'b0010, 1'b0, 4'b1100, 1'b0, 0);
    idle_cycle();
    op(4'b1010, 4'b1011, 1'b0, 4'b1111, 1'b1, 0);
    idle_cycle();
    op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 0);
    idle_cycle();
    op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1);
    idle_cycle();

    // Asynchronous reset just after E2 of an operation
    start = 1'b1; A = 4'b1100; B = 4'b0011; Bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_diff", int'(Diff), 0);
    chk("arst_bout", int'(Bout), 0);
    @(negedge clk);
    rst = 1'b0;
    prev_d = '0; prev_b = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(done), 0);
    end
    op(4'b0111, 4'b0001, 1'b1, 4'b0101, 1'b0, 0);
    idle_cycle();

    // Exhaustive sweep, chained back-to-back
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a, b;
      logic bin;
      a = i[3:0]; b = i[7:4]; bin = i[8];
      r = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
      op(a, b, bin, r[3:0], r[4], 0);
    end
    idle_cycle();
    repeat (4) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", dones, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
